imem_wb_loader: RTL

- Wishbone classic responder that loads and reads back the SLRV instruction SRAM (sky130 32x512, port 0) from the management SoC.
- Replaces logic-analyzer loading of port 0. Port 1 stays owned by the core fetch path.
- Provides a control register that holds the core in reset while the program is loaded, plus a write counter for load checking.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_wb_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-SRAM Wishbone loader:
// FSM states and the register offsets inside the block's window.
package imem_loader_pkg;

  localparam int unsigned OFF_W = 16;

  localparam logic [OFF_W-1:0] IMEM_LIMIT = 16'h0800;
  localparam logic [OFF_W-1:0] CTRL_OFF   = 16'h1000;
  localparam logic [OFF_W-1:0] WCNT_OFF   = 16'h1004;

  localparam int unsigned CTRL_HOLD_BIT = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RDW  = 3'd3,
    ACK  = 3'd4
  } stateT;

endpackage

// File: rtl/imem_wb_loader.sv
// Wishbone classic responder that loads/reads the instruction SRAM through port 0
// and exposes a core-hold control bit plus a completed-write counter.
module imem_wb_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  input  logic [31:0]       sram_dout0,
  output logic              core_hold_o
);

  stateT             state, stateNext;
  logic [CNT_W-1:0]  wCnt, wCntNext;
  logic              ackNext, csbNext, webNext, holdNext;
  logic [3:0]        wmaskNext;
  logic [ADDR_W-1:0] addrNext;
  logic [31:0]       dinNext, datNext;
  logic              holdPend, holdPendNext, holdVal, holdValNext;
  logic              clrPend, clrPendNext;

  logic              blockSel, isImem, isCtrl, isWcnt, req;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       regRd;

  // Address decode within the block's window
  assign offset   = wbs_adr_i[OFF_W-1:0];
  assign blockSel = (wbs_adr_i[31:OFF_W] == BASE_ADDR[31:OFF_W]);
  assign isImem   = blockSel && (offset < IMEM_LIMIT);
  assign isCtrl   = blockSel && (offset == CTRL_OFF);
  assign isWcnt   = blockSel && (offset == WCNT_OFF);
  assign wordIdx  = wbs_adr_i[ADDR_W+1:2];
  assign req      = wbs_cyc_i && wbs_stb_i && !wbs_ack_o && blockSel;

  // Register read mux; unmapped offsets read as zero
  always_comb begin
    regRd = '0;
    if (isCtrl) begin
      regRd[CTRL_HOLD_BIT] = core_hold_o;
    end else if (isWcnt) begin
      regRd = 32'(wCnt);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    ackNext      = 1'b0;
    csbNext      = 1'b1;
    webNext      = 1'b1;
    wmaskNext    = sram_wmask0;
    addrNext     = sram_addr0;
    dinNext      = sram_din0;
    datNext      = wbs_dat_o;
    holdNext     = core_hold_o;
    wCntNext     = wCnt;
    holdPendNext = holdPend;
    holdValNext  = holdVal;
    clrPendNext  = clrPend;

    case (state)
      IDLE: begin
        if (req) begin
          if (isImem && wbs_we_i && (wbs_sel_i != 4'b0000)) begin
            stateNext = WR;
            csbNext   = 1'b0;
            webNext   = 1'b0;
            wmaskNext = wbs_sel_i;
            addrNext  = wordIdx;
            dinNext   = wbs_dat_i;
          end else if (isImem && !wbs_we_i) begin
            stateNext = RD;
            csbNext   = 1'b0;
            addrNext  = wordIdx;
          end else begin
            stateNext = ACK;
            ackNext   = 1'b1;
            if (!wbs_we_i) begin
              datNext = regRd;
            end else begin
              holdPendNext = isCtrl && wbs_sel_i[0];
              holdValNext  = wbs_dat_i[CTRL_HOLD_BIT];
              clrPendNext  = isWcnt;
            end
          end
        end
      end
      WR: begin
        // The write was issued on entry, so it counts even when the cycle aborts
        wCntNext = (wCnt == '1) ? wCnt : wCnt + CNT_W'(1);
        if (wbs_cyc_i) begin
          stateNext = ACK;
          ackNext   = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      RD: begin
        stateNext = wbs_cyc_i ? RDW : IDLE;
      end
      RDW: begin
        if (wbs_cyc_i) begin
          stateNext = ACK;
          ackNext   = 1'b1;
          datNext   = sram_dout0;
        end else begin
          stateNext = IDLE;
        end
      end
      ACK: begin
        stateNext    = IDLE;
        holdPendNext = 1'b0;
        clrPendNext  = 1'b0;
        if (holdPend) begin
          holdNext = holdVal;
        end
        if (clrPend) begin
          wCntNext = '0;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      core_hold_o <= 1'b1;
      wCnt        <= '0;
      holdPend    <= 1'b0;
      holdVal     <= 1'b1;
      clrPend     <= 1'b0;
    end else begin
      wbs_ack_o   <= ackNext;
      wbs_dat_o   <= datNext;
      sram_csb0   <= csbNext;
      sram_web0   <= webNext;
      sram_wmask0 <= wmaskNext;
      sram_addr0  <= addrNext;
      sram_din0   <= dinNext;
      core_hold_o <= holdNext;
      wCnt        <= wCntNext;
      holdPend    <= holdPendNext;
      holdVal     <= holdValNext;
      clrPend     <= clrPendNext;
    end
  end

endmodule
